// File: rtl/core_pkg.sv
// core_pkg: shared RV64I decode constants, ALU op encoding and the ID/EX bundle.
// No ports; imported by id_stage and regfile.
package core_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_FUNCT  = 2'b10,
      ALU_LUI    = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    jump;
      logic    alu_src;
      logic    mem_to_reg;
      logic    word_op;
      logic    illegal;
      alu_op_e alu_op;
   } ctrl_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [63:0] rs1_data;
      logic [63:0] rs2_data;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        funct7b5;
      ctrl_t       ctrl;
   } id_ex_t;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 32 x 64 integer registers, two async read ports, one sync write port.
// Ports: clk, rst (sync, active-low, clears all), ra1/ra2 -> rd1/rd2, we/wa/wd write.
// Macro ID_RF_BYPASS_EN: a same-cycle write to a read register forwards wd.
module regfile
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [63:0] rd1,
   output logic [63:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [63:0] wd
);

   logic [63:0] regs [32];
   logic        wr_en;

   assign wr_en = we && (wa != 5'd0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
      rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
`ifdef ID_RF_BYPASS_EN
      if (wr_en && (wa == ra1)) begin
         rd1 = wd;
      end
      if (wr_en && (wa == ra2)) begin
         rd2 = wd;
      end
`endif
   end

endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID register, RV64I decode, load-use hazard detect, ID/EX register.
// Ports: clk, rst (sync, active-low); if_pc/if_instr from fetch; flush from EX;
//   wb_we/wb_rd/wb_data write-back; pc_stall to fetch; id_* registered ID/EX bundle.
// Macro ID_RF_BYPASS_EN (in regfile): forward write-back data to same-cycle reads.
module id_stage
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] if_pc,
   input  logic [31:0] if_instr,
   input  logic        flush,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [63:0] wb_data,
   output logic        pc_stall,
   output logic        id_valid,
   output logic [63:0] id_pc,
   output logic [63:0] id_rs1_data,
   output logic [63:0] id_rs2_data,
   output logic [63:0] id_imm,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic [4:0]  id_rd,
   output logic [2:0]  id_funct3,
   output logic        id_funct7b5,
   output logic        id_reg_write,
   output logic        id_mem_read,
   output logic        id_mem_write,
   output logic        id_branch,
   output logic        id_jump,
   output logic        id_alu_src,
   output logic        id_mem_to_reg,
   output logic        id_word_op,
   output logic        id_illegal,
   output logic [1:0]  id_alu_op
);

   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;

   logic [6:0]  opcode;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] imm32;
   ctrl_t       ctrl;
   logic        use_rs1;
   logic        use_rs2;
   logic [63:0] rs1_rdata;
   logic [63:0] rs2_rdata;
   logic        hazard;

   id_ex_t      ex_d;
   id_ex_t      ex_q;

   // IF/ID: a squashed or reset slot holds a NOP marked invalid
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         ifid_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else if (!pc_stall) begin
         ifid_pc    <= if_pc;
         ifid_instr <= if_instr;
         ifid_valid <= 1'b1;
      end
   end

   assign opcode  = ifid_instr[6:0];
   assign dec_rd  = ifid_instr[11:7];
   assign dec_rs1 = ifid_instr[19:15];
   assign dec_rs2 = ifid_instr[24:20];

   assign imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
   assign imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25],
                   ifid_instr[11:7]};
   assign imm_b = {{19{ifid_instr[31]}}, ifid_instr[31],
                   ifid_instr[7], ifid_instr[30:25],
                   ifid_instr[11:8], 1'b0};
   assign imm_u = {ifid_instr[31:12], 12'b0};
   assign imm_j = {{11{ifid_instr[31]}}, ifid_instr[31],
                   ifid_instr[19:12], ifid_instr[20],
                   ifid_instr[30:21], 1'b0};

   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      imm32       = '0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      unique case (opcode)
         OPC_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            imm32           = imm_i;
            use_rs1         = 1'b1;
         end
         OPC_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            imm32          = imm_s;
            use_rs1        = 1'b1;
            use_rs2        = 1'b1;
         end
         OPC_OP_IMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
            imm32          = imm_i;
            use_rs1        = 1'b1;
         end
         OPC_OP: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
            use_rs1        = 1'b1;
            use_rs2        = 1'b1;
         end
         OPC_OP_IMM_32: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.word_op   = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
            imm32          = imm_i;
            use_rs1        = 1'b1;
         end
         OPC_OP_32: begin
            ctrl.reg_write = 1'b1;
            ctrl.word_op   = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
            use_rs1        = 1'b1;
            use_rs2        = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_BRANCH;
            imm32       = imm_b;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
         end
         OPC_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            imm32          = imm_j;
         end
         OPC_JALR: begin
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.alu_src   = 1'b1;
            imm32          = imm_i;
            use_rs1        = 1'b1;
         end
         OPC_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_LUI;
            imm32          = imm_u;
         end
         OPC_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            imm32          = imm_u;
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
   end

   regfile u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (dec_rs1),
      .ra2 (dec_rs2),
      .rd1 (rs1_rdata),
      .rd2 (rs2_rdata),
      .we  (wb_we),
      .wa  (wb_rd),
      .wd  (wb_data)
   );

   // only a real load in ID/EX can hazard a real consumer in IF/ID
   assign hazard = ex_q.valid && ex_q.ctrl.mem_read &&
                   (ex_q.rd != 5'd0) && ifid_valid &&
                   ((use_rs1 && (ex_q.rd == dec_rs1)) ||
                    (use_rs2 && (ex_q.rd == dec_rs2)));

   assign pc_stall = rst && !flush && hazard;

   always_comb begin
      ex_d          = '0;
      ex_d.valid    = 1'b1;
      ex_d.pc       = ifid_pc;
      ex_d.rs1_data = rs1_rdata;
      ex_d.rs2_data = rs2_rdata;
      ex_d.imm      = sext32(imm32);
      ex_d.rs1      = dec_rs1;
      ex_d.rs2      = dec_rs2;
      ex_d.rd       = dec_rd;
      ex_d.funct3   = ifid_instr[14:12];
      ex_d.funct7b5 = ifid_instr[30];
      ex_d.ctrl     = ctrl;
   end

   always_ff @(posedge clk) begin
      if (!rst || flush || pc_stall || !ifid_valid) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign id_valid      = ex_q.valid;
   assign id_pc         = ex_q.pc;
   assign id_rs1_data   = ex_q.rs1_data;
   assign id_rs2_data   = ex_q.rs2_data;
   assign id_imm        = ex_q.imm;
   assign id_rs1        = ex_q.rs1;
   assign id_rs2        = ex_q.rs2;
   assign id_rd         = ex_q.rd;
   assign id_funct3     = ex_q.funct3;
   assign id_funct7b5   = ex_q.funct7b5;
   assign id_reg_write  = ex_q.ctrl.reg_write;
   assign id_mem_read   = ex_q.ctrl.mem_read;
   assign id_mem_write  = ex_q.ctrl.mem_write;
   assign id_branch     = ex_q.ctrl.branch;
   assign id_jump       = ex_q.ctrl.jump;
   assign id_alu_src    = ex_q.ctrl.alu_src;
   assign id_mem_to_reg = ex_q.ctrl.mem_to_reg;
   assign id_word_op    = ex_q.ctrl.word_op;
   assign id_illegal    = ex_q.ctrl.illegal;
   assign id_alu_op     = ex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage; directed cases then random traffic
// against an instruction-level reference model.
module tb_id_stage;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] if_pc = '0;
   logic [31:0] if_instr = 32'h13;
   logic        flush = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [63:0] wb_data = '0;
   logic        pc_stall, id_valid;
   logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_funct3;
   logic        id_funct7b5, id_reg_write, id_mem_read, id_mem_write;
   logic        id_branch, id_jump, id_alu_src, id_mem_to_reg;
   logic        id_word_op, id_illegal;
   logic [1:0]  id_alu_op;
   logic [10:0] dut_ctrl;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
      .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .pc_stall(pc_stall), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_branch(id_branch),
      .id_jump(id_jump), .id_alu_src(id_alu_src),
      .id_mem_to_reg(id_mem_to_reg), .id_word_op(id_word_op),
      .id_illegal(id_illegal), .id_alu_op(id_alu_op)
   );

   assign dut_ctrl = {id_reg_write, id_mem_read, id_mem_write, id_branch,
                      id_jump, id_alu_src, id_mem_to_reg, id_word_op,
                      id_illegal, id_alu_op};

   typedef struct packed {
      logic [63:0] pc, imm, d1, d2;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        f7b5;
      logic [10:0] ctl;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] m_regs [32];
   logic        m_if_v = 1'b0;
   logic [63:0] m_if_pc = '0;
   logic [31:0] m_if_ins = 32'h13;
   logic        m_ex_v = 1'b0;
   logic        m_ex_ld = 1'b0;
   logic [4:0]  m_ex_rd = '0;
   logic        last_stall;
   logic [63:0] bypass_exp;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // sign-extend the low n bits of v
   function automatic logic [63:0] sx(input logic [31:0] v, input int n);
      logic signed [63:0] t;
      t = $signed({32'b0, v} << (64 - n));
      return t >>> (64 - n);
   endfunction

   function automatic logic [63:0] rf_read(input logic [4:0] r);
      if (r == 5'd0) return '0;
`ifdef ID_RF_BYPASS_EN
      if (wb_we && wb_rd == r) return wb_data;
`endif
      return m_regs[r];
   endfunction

   function automatic void uses(input logic [31:0] ins,
                                output logic u1, output logic u2);
      case (ins[6:0])
         7'h03, 7'h13, 7'h1B, 7'h67: begin u1 = 1; u2 = 0; end
         7'h23, 7'h33, 7'h3B, 7'h63: begin u1 = 1; u2 = 1; end
         default: begin u1 = 0; u2 = 0; end
      endcase
   endfunction

   // ctl = {rw, mr, mw, br, jp, as, m2r, wo, ill, aop[1:0]}
   function automatic exp_t predict(input logic [63:0] pc,
                                    input logic [31:0] w);
      exp_t e;
      logic [31:0] vi, vs, vb, vu, vj;
      vi = {20'b0, w[31:20]};
      vs = {20'b0, w[31:25], w[11:7]};
      vb = {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0};
      vu = {w[31:12], 12'b0};
      vj = {11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0};
      e      = '0;
      e.pc   = pc;
      e.rd   = w[11:7];
      e.rs1  = w[19:15];
      e.rs2  = w[24:20];
      e.f3   = w[14:12];
      e.f7b5 = w[30];
      e.d1   = rf_read(w[19:15]);
      e.d2   = rf_read(w[24:20]);
      case (w[6:0])
         7'h03: begin e.ctl = 11'b11000110000; e.imm = sx(vi, 12); end
         7'h23: begin e.ctl = 11'b00100100000; e.imm = sx(vs, 12); end
         7'h13: begin e.ctl = 11'b10000100010; e.imm = sx(vi, 12); end
         7'h33: begin e.ctl = 11'b10000000010; e.imm = '0; end
         7'h1B: begin e.ctl = 11'b10000101010; e.imm = sx(vi, 12); end
         7'h3B: begin e.ctl = 11'b10000001010; e.imm = '0; end
         7'h63: begin e.ctl = 11'b00010000001; e.imm = sx(vb, 13); end
         7'h6F: begin e.ctl = 11'b10001000000; e.imm = sx(vj, 21); end
         7'h67: begin e.ctl = 11'b10001100000; e.imm = sx(vi, 12); end
         7'h37: begin e.ctl = 11'b10000100011; e.imm = sx(vu, 32); end
         7'h17: begin e.ctl = 11'b10000100000; e.imm = sx(vu, 32); end
         default: begin e.ctl = 11'b00000000100; e.imm = '0; end
      endcase
      return e;
   endfunction

   task automatic step(input logic r, input logic f,
                       input logic [63:0] pc, input logic [31:0] ins,
                       input logic we, input logic [4:0] wa,
                       input logic [63:0] wd);
      exp_t e;
      logic st, u1, u2;
      @(negedge clk);
      rst = r; flush = f; if_pc = pc; if_instr = ins;
      wb_we = we; wb_rd = wa; wb_data = wd;
      #1;
      uses(m_if_ins, u1, u2);
      st = r && !f && m_ex_v && m_ex_ld && (m_ex_rd != 0) && m_if_v &&
           ((u1 && m_ex_rd == m_if_ins[19:15]) ||
            (u2 && m_ex_rd == m_if_ins[24:20]));
      chk("pc_stall", 64'(pc_stall), 64'(st));
      last_stall = pc_stall;
      e = predict(m_if_pc, m_if_ins);
      @(posedge clk);
      if (!r) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_if_v = 0; m_if_pc = '0; m_if_ins = 32'h13;
         m_ex_v = 0; m_ex_ld = 0; m_ex_rd = '0;
      end else begin
         if (we && wa != 0) m_regs[wa] = wd;
         if (f) begin
            m_if_v = 0; m_if_pc = '0; m_if_ins = 32'h13;
            m_ex_v = 0; m_ex_ld = 0;
         end else if (st) begin
            m_ex_v = 0; m_ex_ld = 0;
         end else begin
            if (m_if_v) begin
               q.push_back(e);
               m_ex_v = 1; m_ex_ld = e.ctl[9]; m_ex_rd = e.rd;
            end else begin
               m_ex_v = 0; m_ex_ld = 0;
            end
            m_if_v = 1; m_if_pc = pc; m_if_ins = ins;
         end
      end
      #2;
   endtask

   function automatic logic [31:0] gen();
      logic [31:0] w;
      int k;
      w = $urandom;
      w[11:10] = 2'b0;
      w[19:18] = 2'b0;
      w[24:23] = 2'b0;
      k = $urandom_range(0, 15);
      case (k)
         0: w[6:0] = 7'h23;
         1: w[6:0] = 7'h13;
         2: w[6:0] = 7'h33;
         3: w[6:0] = 7'h1B;
         4: w[6:0] = 7'h3B;
         5: w[6:0] = 7'h63;
         6: w[6:0] = 7'h6F;
         7: w[6:0] = 7'h67;
         8: w[6:0] = 7'h37;
         9: w[6:0] = 7'h17;
         10, 11, 12, 13: w[6:0] = 7'h03;
         14: w[6:0] = 7'h73;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("valid", 64'(id_valid), 64'd1);
            chk("pc", id_pc, mon_e.pc);
            chk("imm", id_imm, mon_e.imm);
            chk("rs1_data", id_rs1_data, mon_e.d1);
            chk("rs2_data", id_rs2_data, mon_e.d2);
            chk("rd", 64'(id_rd), 64'(mon_e.rd));
            chk("rs1", 64'(id_rs1), 64'(mon_e.rs1));
            chk("rs2", 64'(id_rs2), 64'(mon_e.rs2));
            chk("funct", 64'({id_funct3, id_funct7b5}),
                64'({mon_e.f3, mon_e.f7b5}));
            chk("ctrl", 64'(dut_ctrl), 64'(mon_e.ctl));
         end else begin
            chk("bubble_valid", 64'(id_valid), 64'd0);
            chk("bubble_ctrl", 64'(dut_ctrl), 64'd0);
         end
      end
   end

   initial begin
      logic [63:0] rpc;
      step(0, 0, 0, 32'h13, 0, 0, 0);
      step(0, 1, 0, 32'h13, 1, 3, 64'h77);
      chk("rst_valid", 64'(id_valid), 64'd0);
      chk("rst_stall", 64'(last_stall), 64'd0);
      chk("rst_pc", id_pc, 64'd0);
      chk("rst_imm", id_imm, 64'd0);

      step(1, 0, 0, 32'h00108093, 0, 0, 0);
      step(1, 0, 4, 32'h13, 0, 0, 0);
      chk("addi_valid", 64'(id_valid), 64'd1);
      chk("addi_rd", 64'(id_rd), 64'd1);
      chk("addi_rs1", 64'(id_rs1), 64'd1);
      chk("addi_imm", id_imm, 64'd1);
      chk("addi_src", 64'(id_alu_src), 64'd1);
      chk("addi_rw", 64'(id_reg_write), 64'd1);

      step(1, 0, 8, 32'hFFF00093, 0, 0, 0);
      step(1, 0, 12, 32'h13, 0, 0, 0);
      chk("neg_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("neg_rs1d", id_rs1_data, 64'd0);

      step(1, 0, 16, 32'h0020B423, 0, 0, 0);
      step(1, 0, 20, 32'h13, 0, 0, 0);
      chk("sd_mw", 64'(id_mem_write), 64'd1);
      chk("sd_rw", 64'(id_reg_write), 64'd0);
      chk("sd_imm", id_imm, 64'd8);
      chk("sd_rs2", 64'(id_rs2), 64'd2);

      step(1, 0, 24, 32'h0000B103, 0, 0, 0);
      step(1, 0, 28, 32'h00210193, 0, 0, 0);
      step(1, 0, 32, 32'h13, 0, 0, 0);
      chk("lu_stall", 64'(last_stall), 64'd1);
      chk("lu_bubble", 64'(id_valid), 64'd0);
      step(1, 0, 32, 32'h13, 0, 0, 0);
      chk("lu_stall_end", 64'(last_stall), 64'd0);
      chk("lu_issue", 64'(id_valid), 64'd1);
      chk("lu_rs1", 64'(id_rs1), 64'd2);
      chk("lu_pc", id_pc, 64'd28);

      step(1, 0, 36, 32'h13, 1, 5, 64'h1111);
      step(1, 0, 40, 32'h00028313, 0, 0, 0);
      step(1, 0, 44, 32'h13, 1, 5, 64'hDEAD);
`ifdef ID_RF_BYPASS_EN
      bypass_exp = 64'hDEAD;
`else
      bypass_exp = 64'h1111;
`endif
      chk("rf_bypass", id_rs1_data, bypass_exp);
      step(1, 0, 48, 32'h00000313, 1, 0, 64'h55);
      step(1, 0, 52, 32'h13, 0, 0, 0);
      chk("x0_read", id_rs1_data, 64'd0);

      step(1, 0, 56, 32'h0000B103, 0, 0, 0);
      step(1, 0, 60, 32'h00210193, 0, 0, 0);
      step(1, 1, 64, 32'h13, 0, 0, 0);
      chk("fl_stall", 64'(last_stall), 64'd0);
      chk("fl_valid", 64'(id_valid), 64'd0);
      step(1, 0, 100, 32'h00500393, 0, 0, 0);
      chk("fl_nop", 64'(id_valid), 64'd0);
      step(1, 0, 104, 32'h13, 0, 0, 0);
      chk("fl_new_pc", id_pc, 64'd100);
      chk("fl_new_imm", id_imm, 64'd5);

      rpc = 64'h1000;
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
              rpc, gen(), ($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 7)), {$urandom, $urandom});
         rpc = rpc + 64'd4;
      end

      step(0, 0, 0, 32'h13, 0, 0, 0);
      step(0, 0, 0, 32'h13, 0, 0, 0);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
